// File: rtl/trim_rx.sv
// Serial trim-code receiver: rebuilds LSB-first trim words from an async bit
// clock and data line, checks frame length and the +1 sweep sequence.
module trim_rx #(
  parameter int NBITS      = 12,
  parameter int GAP_CYCLES = 75000000,
  parameter int GCW        = 27
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             EN,
  input  logic             SCLK,
  input  logic             SDIN,
  output logic [NBITS-1:0] CODE,
  output logic             CODE_VALID,
  output logic             FRAME_ERR,
  output logic             SEQ_ERR,
  output logic             BUSY,
  output logic [15:0]      FRAME_CNT
);

  // state  | meaning
  // IDLE   | waiting for the first SCLK fall of a frame
  // RECV   | shifting bits in, watching the inter-fall gap
  // DONE   | one cycle: judge length/sequence, emit pulses

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int BCW = $clog2(NBITS + 2);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [BCW-1:0] BIT_FULL = BCW'(NBITS);
  localparam logic [BCW-1:0] BIT_SAT  = BCW'(NBITS + 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);
  localparam logic [GCW-1:0] GAP_ONE  = GCW'(1);
  localparam logic [NBITS-1:0] CODE_ONE = NBITS'(1);

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sdin_s1_q, sdin_s2_q;
  logic fall;

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] sreg_q, sreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [GCW-1:0]   gap_q, gap_d;
  logic [NBITS-1:0] code_q, code_d;
  logic [NBITS-1:0] code_inc;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             serr_q, serr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             have_prev_q, have_prev_d;

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      sdin_s1_q <= 1'b0;
      sdin_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      sdin_s1_q <= SDIN;
      sdin_s2_q <= sdin_s1_q;
    end
  end

  // Source changes data on the rising edge, so the falling edge is mid-bit.
  assign fall     = ~sclk_s2_q & sclk_s3_q;
  assign code_inc = code_q + CODE_ONE;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bitcnt_d    = bitcnt_q;
    gap_d       = gap_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    serr_d      = 1'b0;
    cnt_d       = cnt_q;
    have_prev_d = have_prev_q;

    case (state_q)
      S_IDLE: begin
        sreg_d   = '0;
        bitcnt_d = '0;
        gap_d    = '0;
        if (fall && EN) begin
          sreg_d   = {sdin_s2_q, {(NBITS-1){1'b0}}};
          bitcnt_d = BIT_ONE;
          state_d  = S_RECV;
        end
      end

      S_RECV: begin
        if (!EN) begin
          state_d  = S_IDLE;
          sreg_d   = '0;
          bitcnt_d = '0;
          gap_d    = '0;
        end else if (fall) begin
          sreg_d = {sdin_s2_q, sreg_q[NBITS-1:1]};
          if (bitcnt_q != BIT_SAT) begin
            bitcnt_d = bitcnt_q + BIT_ONE;
          end
          gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_DONE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (bitcnt_q == BIT_FULL) begin
          code_d      = sreg_q;
          valid_d     = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          serr_d      = have_prev_q && (sreg_q != code_inc);
          have_prev_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disabling the receiver breaks the sweep history.
    if (!EN) begin
      have_prev_d = 1'b0;
    end
  end

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      bitcnt_q    <= '0;
      gap_q       <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      serr_q      <= 1'b0;
      cnt_q       <= '0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bitcnt_q    <= bitcnt_d;
      gap_q       <= gap_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      serr_q      <= serr_d;
      cnt_q       <= cnt_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign CODE       = code_q;
  assign CODE_VALID = valid_q;
  assign FRAME_ERR  = ferr_q;
  assign SEQ_ERR    = serr_q;
  assign BUSY       = (state_q == S_RECV);
  assign FRAME_CNT  = cnt_q;

endmodule
